// File: rtl/npu_pkg.sv
// Shared NPU constants and the lane-sequencer state type.
// Window-control blocks that walk lanes reuse these.
package npu_pkg;

  localparam int LANE_CNT = 9;  // 3x3 PE window
  localparam int CNT_W    = 4;  // enough bits to hold 0..LANE_CNT

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/count_to_lane_sequencer_if.sv
// Count-in / lane-beat-out handshake bundle.
// The producer and consumer side is "master".
// The sequencer side is "slave".
interface count_to_lane_sequencer_if import npu_pkg::*; #(
  parameter int LANES = LANE_CNT,
  parameter int CW    = CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    in_count;
  logic             out_valid;
  logic             out_ready;
  logic [LANES-1:0] out_lane;
  logic [CW-1:0]    out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_count, out_ready,
    input  in_ready, out_valid, out_lane, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_count, out_ready,
    output in_ready, out_valid, out_lane, out_idx, out_last
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// The head entry is readable combinationally, so a pop and its consumer load can
// happen on the same edge.
module sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [AW:0]      count_next;
  logic             full_reg;
  logic             empty_reg;

  assign dout  = mem[rd_ptr_reg];
  assign full  = full_reg;
  assign empty = empty_reg;

  // Occupancy after this edge. A simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (!push && pop) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Storage array with no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers, occupancy and registered flags.
  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
    end
  end

endmodule

// File: rtl/count_to_lane_sequencer.sv
// Expands a lane count N into N beats of one-hot lane selects (lanes 0..N-1).
// A count of 0 becomes a single empty beat.
// Counts above LANES are saturated on entry and flagged on err_sat.
module count_to_lane_sequencer import npu_pkg::*; #(
  parameter int LANES      = LANE_CNT,
  parameter int CW         = CNT_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  count_to_lane_sequencer_if.slave    bus,
  output logic                        err_sat,
  output logic                        busy
);

  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [CW-1:0] CW_ONE  = CW'(1);

  logic             init_done_reg;
  logic             err_sat_reg;
  logic             push;
  logic             pop;
  logic             over_range;
  logic [CW-1:0]    sat_count;
  logic [CW-1:0]    fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  seq_state_t       state_reg;
  seq_state_t       state_next;
  logic [CW-1:0]    cnt_reg;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    idx_reg;
  logic [CW-1:0]    idx_next;
  logic             last;
  logic             emitting;
  logic [LANES-1:0] lane_dec;

  // in_ready stays low until the first edge after reset release.
  // After that it is simply !full, with no bypass when full.
  assign bus.in_ready = init_done_reg && !fifo_full;
  assign push         = bus.in_valid && bus.in_ready;
  assign over_range   = (bus.in_count > LANES_C);
  assign sat_count    = over_range ? LANES_C : bus.in_count;

  sync_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (sat_count),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Ready gating after reset, and the one-cycle saturation flag for an accepted count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_done_reg <= 1'b0;
      err_sat_reg   <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      err_sat_reg   <= push && over_range;
    end
  end

  assign err_sat  = err_sat_reg;
  assign emitting = (state_reg == EMIT);
  assign busy     = !fifo_empty || emitting;

  // Final beat: either the top lane of the count, or the lone beat of a zero count.
  assign last = (cnt_reg == '0) || (idx_reg == cnt_reg - CW_ONE);

  // Sequencer state, the loaded count and the current lane index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
    end
  end

  // Next state logic. A final-beat transfer with work queued reloads on the
  // same edge, so back-to-back transactions have no bubble between them.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    pop        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          cnt_next   = fifo_dout;
          idx_next   = '0;
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          if (!last) begin
            idx_next = idx_reg + CW_ONE;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            cnt_next = fifo_dout;
            idx_next = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot decode of the lane index. A zero count decodes to no lane.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_dec
    assign lane_dec[gi] = emitting && (cnt_reg != '0) && (idx_reg == CW'(gi));
  end

  // Output payload is a pure function of registers, so it holds while stalled.
  assign bus.out_valid = emitting;
  assign bus.out_lane  = lane_dec;
  assign bus.out_idx   = emitting ? idx_reg : '0;
  assign bus.out_last  = emitting && last;

endmodule

// File: tb/tb_count_to_lane_sequencer.sv
// Directed bench for count_to_lane_sequencer.
// It runs a table of single transactions, then hand-written back-to-back,
// stall/fill and mid-transaction reset sequences.
module tb_count_to_lane_sequencer;
  import npu_pkg::*;

  localparam int LANES = 9;
  localparam int CW    = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic err_sat;
  logic busy;

  int checks   = 0;
  int failures = 0;

  count_to_lane_sequencer_if #(.LANES(LANES), .CW(CW)) bus ();

  count_to_lane_sequencer #(
    .LANES      (LANES),
    .CW         (CW),
    .FIFO_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .err_sat (err_sat),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0]    count;
    int               beats;
    logic             sat;
    logic [LANES-1:0] final_lane;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [LANES-1:0] exp_lane;
    @(negedge clk);
    check("in_ready_before_push", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_count  = v.count;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("err_sat_after_accept", 32'(err_sat), 32'(v.sat));
    check("no_beat_one_cycle_after_accept", 32'(bus.out_valid), 32'd0);
    for (int k = 0; k < v.beats; k++) begin
      @(negedge clk);
      exp_lane = '0;
      if (v.count != '0) exp_lane[k] = 1'b1;
      check("beat_valid", 32'(bus.out_valid), 32'd1);
      check("beat_lane", 32'(bus.out_lane), 32'(exp_lane));
      check("beat_idx", 32'(bus.out_idx), 32'(k));
      check("beat_last", 32'(bus.out_last), 32'(k == v.beats - 1));
      if (k == 0) check("err_sat_one_cycle", 32'(err_sat), 32'd0);
      if (k == v.beats - 1) check("final_lane", 32'(bus.out_lane), 32'(v.final_lane));
    end
    @(negedge clk);
    check("idle_after_txn_valid", 32'(bus.out_valid), 32'd0);
    check("idle_after_txn_busy", 32'(busy), 32'd0);
    $display("txn count=%0d beats=%0d sat=%0d checks=%0d failures=%0d",
             v.count, v.beats, v.sat, checks, failures);
  endtask

  initial begin
    logic [LANES-1:0] seq_lane [7];
    logic [CW-1:0]    seq_idx  [7];
    logic             seq_last [7];
    int               beat;
    int               cyc;
    logic             xfer;
    vec_t             one;

    vecs[0] = '{count: 4'd3,  beats: 3, sat: 1'b0, final_lane: 9'h004};
    vecs[1] = '{count: 4'd0,  beats: 1, sat: 1'b0, final_lane: 9'h000};
    vecs[2] = '{count: 4'd9,  beats: 9, sat: 1'b0, final_lane: 9'h100};
    vecs[3] = '{count: 4'd12, beats: 9, sat: 1'b1, final_lane: 9'h100};
    vecs[4] = '{count: 4'd1,  beats: 1, sat: 1'b0, final_lane: 9'h001};
    vecs[5] = '{count: 4'd15, beats: 9, sat: 1'b1, final_lane: 9'h100};

    bus.in_valid  = 1'b0;
    bus.in_count  = '0;
    bus.out_ready = 1'b0;

    // Values held during reset, and the ready rise one cycle after release.
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_lane", 32'(bus.out_lane), 32'd0);
    check("rst_out_idx", 32'(bus.out_idx), 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_err_sat", 32'(err_sat), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b1;
    #1;
    check("in_ready_low_at_release", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("in_ready_high_after_release", 32'(bus.in_ready), 32'd1);

    // Table of isolated transactions.
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // Back-to-back 2 then 1: three beats with no bubble.
    seq_lane[0] = 9'h001; seq_idx[0] = 4'd0; seq_last[0] = 1'b0;
    seq_lane[1] = 9'h002; seq_idx[1] = 4'd1; seq_last[1] = 1'b1;
    seq_lane[2] = 9'h001; seq_idx[2] = 4'd0; seq_last[2] = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_count  = 4'd2;
    @(negedge clk);
    check("b2b_in_ready_second", 32'(bus.in_ready), 32'd1);
    bus.in_count = 4'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("b2b_valid", 32'(bus.out_valid), 32'd1);
      check("b2b_lane", 32'(bus.out_lane), 32'(seq_lane[k]));
      check("b2b_idx", 32'(bus.out_idx), 32'(seq_idx[k]));
      check("b2b_last", 32'(bus.out_last), 32'(seq_last[k]));
      @(negedge clk);
    end
    check("b2b_idle_valid", 32'(bus.out_valid), 32'd0);
    $display("txn back_to_back 2,1 checks=%0d failures=%0d", checks, failures);

    // Push 4, 2, 1 with a stalled consumer. The FIFO fills, then beats drain
    // with out_ready toggling 1,0,1,0.
    seq_lane[0] = 9'h001; seq_idx[0] = 4'd0; seq_last[0] = 1'b0;
    seq_lane[1] = 9'h002; seq_idx[1] = 4'd1; seq_last[1] = 1'b0;
    seq_lane[2] = 9'h004; seq_idx[2] = 4'd2; seq_last[2] = 1'b0;
    seq_lane[3] = 9'h008; seq_idx[3] = 4'd3; seq_last[3] = 1'b1;
    seq_lane[4] = 9'h001; seq_idx[4] = 4'd0; seq_last[4] = 1'b0;
    seq_lane[5] = 9'h002; seq_idx[5] = 4'd1; seq_last[5] = 1'b1;
    seq_lane[6] = 9'h001; seq_idx[6] = 4'd0; seq_last[6] = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_count  = 4'd4;
    @(negedge clk);
    check("fill_in_ready_2", 32'(bus.in_ready), 32'd1);
    bus.in_count = 4'd2;
    @(negedge clk);
    check("fill_in_ready_3", 32'(bus.in_ready), 32'd1);
    bus.in_count = 4'd1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("fill_in_ready_full", 32'(bus.in_ready), 32'd0);
    check("fill_busy", 32'(busy), 32'd1);
    beat = 0;
    cyc  = 0;
    while (beat < 7 && cyc < 60) begin
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_lane", 32'(bus.out_lane), 32'(seq_lane[beat]));
      check("stall_idx", 32'(bus.out_idx), 32'(seq_idx[beat]));
      check("stall_last", 32'(bus.out_last), 32'(seq_last[beat]));
      bus.out_ready = (cyc % 2 == 0);
      xfer = bus.out_valid && bus.out_ready;
      @(negedge clk);
      if (xfer) beat++;
      cyc++;
    end
    check("stall_drain_beats", 32'(beat), 32'd7);
    check("stall_idle_valid", 32'(bus.out_valid), 32'd0);
    check("stall_idle_busy", 32'(busy), 32'd0);
    check("stall_idle_in_ready", 32'(bus.in_ready), 32'd1);
    $display("txn stall_fill 4,2,1 beats=%0d checks=%0d failures=%0d", beat, checks, failures);

    // Reset in the middle of a count-5 transaction, with a count-7 still queued.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_count  = 4'd5;
    @(negedge clk);
    bus.in_count = 4'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_emit_idx", 32'(bus.out_idx), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("async_rst_out_lane", 32'(bus.out_lane), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);
    one = '{count: 4'd1, beats: 1, sat: 1'b0, final_lane: 9'h001};
    run_txn(one);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
